sb_bus_arbiter: RTL and testbench
=================================

Name: sb_bus_arbiter

Overview:
- Shares the iCE40UP hard-IP system bus (SB, 8-bit address and data, strobe/ack) between two fabric requesters. Typical requesters are the I2C configuration sequencer and the host bridge.
- Sequences one SB transaction at a time: latches the request, drives the strobe until ack, captures read data, and returns a one-cycle done pulse to the owning requester.
- Sits between the requesters and the I2C/SPI hard-IP SB ports.

Parameters:
- TIMEOUT_CYCLES, 255: SB_STB cycles without SB_ACK before a transaction is aborted. Range 1..255; 8-bit counter. Used only with SB_TIMEOUT_EN.

Ports:
- SBCLKI  in  1  SB clock, shared with the hard IP; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- R0_REQ, R1_REQ  in  1  transaction request; held high until the matching DONE pulse.
- R0_WE, R1_WE  in  1  1 = write, 0 = read; sampled at grant.
- R0_ADR, R1_ADR  in  8  SB address; sampled at grant.
- R0_WDAT, R1_WDAT  in  8  write data; sampled at grant.
- R0_DONE, R1_DONE  out  1  one-cycle completion pulse.
- R0_RDAT, R1_RDAT  out  8  read data; valid from DONE and held until that requester's next successful read.
- R0_ERR, R1_ERR  out  1  qualifies DONE: 1 = timed out.
- SB_STB  out  1  to the hard-IP SBSTBI.
- SB_RW  out  1  to SBRWI (1 = write).
- SB_ADR  out  8  to SBADRI7..0.
- SB_WDAT  out  8  to SBDATI7..0.
- SB_RDAT  in  8  from SBDATO7..0.
- SB_ACK  in  1  from SBACKO.

Behaviour:
- Reset, asynchronous and taking effect immediately even mid-transaction:
  - All outputs 0: SB_STB, SB_RW, SB_ADR, SB_WDAT, Rn_DONE, Rn_RDAT, Rn_ERR.
  - FSM = IDLE; last_grant = 1, so R0 wins the first contention; timeout counter = 0.
- FSM states: IDLE, BUS, DONE. All outputs are registered.
- IDLE:
  - If any Rn_REQ=1, select a winner. With a single requester, grant it. With both, grant the one that is not last_grant (round robin).
  - Latch the winner's WE/ADR/WDAT into SB_RW/SB_ADR/SB_WDAT, set SB_STB=1, update last_grant, go to BUS.
  - The first strobe cycle is therefore the cycle after REQ is sampled.
- BUS:
  - SB_STB, SB_RW, SB_ADR and SB_WDAT are held stable.
  - On a cycle where SB_ACK=1: capture SB_RDAT into the owner's Rn_RDAT (reads only; writes leave it unchanged), clear SB_STB, go to DONE.
- DONE:
  - Owner's Rn_DONE=1 for exactly this cycle; SB_STB=0. This provides the mandatory one idle strobe cycle between SB transactions.
  - Always returns to IDLE.
- Requester contract:
  - Drop REQ in the DONE cycle or earlier. A REQ still high in IDLE starts a new transaction.
  - Minimum spacing of strobes is 3 cycles: IDLE, BUS with immediate ack, DONE.
- Boundary rules:
  - REQ dropped during BUS: the transaction completes and DONE still pulses.
  - SB_ACK in IDLE or DONE: ignored.
  - Non-owner REQ during BUS/DONE: waits; it is granted at the next IDLE if still high.
  - SB_ADR/SB_WDAT keep their last value after DONE; SB_STB=0 qualifies them.
  - A read returning 8'h00 is legal and is stored as-is.

Optional Feature:
- Macro: SB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with SB_ACK=0, clear SB_STB and go to DONE with the owner's Rn_ERR=1 alongside Rn_DONE. Rn_RDAT is unchanged.
  - SB_ACK arriving in the same cycle as the timeout wins: the transaction completes normally with ERR=0.
  - Rn_ERR is 1 only in the DONE cycle.
- Undefined: BUS waits indefinitely for SB_ACK; R0_ERR and R1_ERR are tied 0; the counter is not built.

Test Plan:
- Write:
  - Stimulus: R0_REQ=1, WE=1, ADR=8'h18, WDAT=8'hA5 in IDLE at cycle 0; SB_ACK=1 at cycle 2.
  - Required: SB_STB=1 with RW=1, ADR=18, WDAT=A5 in cycles 1-2; R0_DONE=1 and SB_STB=0 at cycle 3; R0_RDAT unchanged.
- Read:
  - Stimulus: R1 read at ADR=8'h1C; SB_ACK=1 with SB_RDAT=8'h3C at the first strobe cycle.
  - Required: R1_DONE pulses the next cycle; R1_RDAT=3C and held; R0_RDAT unchanged.
- Contention:
  - Stimulus: R0_REQ and R1_REQ both held high from reset, immediate acks, each requester dropping REQ at its DONE.
  - Required: grants are R0 then R1; each requester sees exactly one DONE; SB_STB never stays high across a DONE cycle.
- Timeout (SB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: R0 read, SB_ACK never asserted.
  - Required: SB_STB high for 4 cycles, then R0_DONE=1 and R0_ERR=1 together; R0_RDAT unchanged. Repeating with ack on the 4th cycle gives ERR=0.
- Reset mid-transaction:
  - Stimulus: assert RST during BUS.
  - Required: SB_STB=0 and all outputs 0 in the same cycle, no DONE pulse; after release, simultaneous requests grant R0 first.
- Late drop:
  - Stimulus: R1 drops REQ during BUS; ack arrives later.
  - Required: R1_DONE still pulses once; FSM returns to IDLE; no new strobe.

Source files
------------

// File: rtl/sb_bus_arbiter.sv
// sb_bus_arbiter: shares the iCE40UP hard-IP system bus between two fabric
// requesters (R0, R1). One SB transaction at a time, round-robin under
// contention, registered outputs throughout.
//
// Optional feature macro: SB_TIMEOUT_EN
//   defined   - an 8-bit strobe watchdog aborts a transaction after
//               TIMEOUT_CYCLES strobe cycles without SB_ACK and flags Rn_ERR
//               alongside Rn_DONE.
//   undefined - BUS waits indefinitely for SB_ACK; R0_ERR/R1_ERR are tied 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; arbitrate pending requests, latch the winner
// BUS     | SB_STB high, address/data/direction held, waiting for SB_ACK
// DONE    | owner's DONE pulse; SB_STB low (mandatory idle strobe cycle)

module sb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       SBCLKI,
    input  logic       RST,

    input  logic       R0_REQ,
    input  logic       R0_WE,
    input  logic [7:0] R0_ADR,
    input  logic [7:0] R0_WDAT,
    output logic       R0_DONE,
    output logic [7:0] R0_RDAT,
    output logic       R0_ERR,

    input  logic       R1_REQ,
    input  logic       R1_WE,
    input  logic [7:0] R1_ADR,
    input  logic [7:0] R1_WDAT,
    output logic       R1_DONE,
    output logic [7:0] R1_RDAT,
    output logic       R1_ERR,

    output logic       SB_STB,
    output logic       SB_RW,
    output logic [7:0] SB_ADR,
    output logic [7:0] SB_WDAT,
    input  logic [7:0] SB_RDAT,
    input  logic       SB_ACK
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;

    // last_grant_q doubles as the owner of the transaction in flight:
    // 0 = R0, 1 = R1. Resets to 1 so R0 wins the first contention.
    logic       last_grant_q, last_grant_d;

    logic       stb_q,  stb_d;
    logic       rw_q,   rw_d;
    logic [7:0] adr_q,  adr_d;
    logic [7:0] wdat_q, wdat_d;

    logic [7:0] r0_rdat_q, r0_rdat_d;
    logic [7:0] r1_rdat_q, r1_rdat_d;
    logic       r0_done_q, r0_done_d;
    logic       r1_done_q, r1_done_d;

    logic       win;

`ifdef SB_TIMEOUT_EN
    // Last count value before the abort fires; the counter starts at 0 on
    // the first strobe cycle, so abort happens on strobe cycle TIMEOUT_CYCLES.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       r0_err_q,  r0_err_d;
    logic       r1_err_q,  r1_err_d;
`endif

    // State register and all registered outputs; reset clears everything at once.
    always_ff @(posedge SBCLKI or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            stb_q        <= 1'b0;
            rw_q         <= 1'b0;
            adr_q        <= 8'h00;
            wdat_q       <= 8'h00;
            r0_rdat_q    <= 8'h00;
            r1_rdat_q    <= 8'h00;
            r0_done_q    <= 1'b0;
            r1_done_q    <= 1'b0;
`ifdef SB_TIMEOUT_EN
            tmo_cnt_q    <= 8'h00;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            stb_q        <= stb_d;
            rw_q         <= rw_d;
            adr_q        <= adr_d;
            wdat_q       <= wdat_d;
            r0_rdat_q    <= r0_rdat_d;
            r1_rdat_q    <= r1_rdat_d;
            r0_done_q    <= r0_done_d;
            r1_done_q    <= r1_done_d;
`ifdef SB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            r0_err_q     <= r0_err_d;
            r1_err_q     <= r1_err_d;
`endif
        end
    end

    // Arbitration, transaction sequencing and next values of every output.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        stb_d        = stb_q;
        rw_d         = rw_q;
        adr_d        = adr_q;
        wdat_d       = wdat_q;
        r0_rdat_d    = r0_rdat_q;
        r1_rdat_d    = r1_rdat_q;
        r0_done_d    = 1'b0;
        r1_done_d    = 1'b0;
        win          = 1'b0;
`ifdef SB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        r0_err_d     = 1'b0;
        r1_err_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (R0_REQ || R1_REQ) begin
                    // Single requester wins outright; under contention the
                    // one that did not have the bus last goes next.
                    if (R0_REQ && R1_REQ) begin
                        win = ~last_grant_q;
                    end else begin
                        win = R1_REQ;
                    end
                    last_grant_d = win;
                    stb_d        = 1'b1;
                    rw_d         = win ? R1_WE   : R0_WE;
                    adr_d        = win ? R1_ADR  : R0_ADR;
                    wdat_d       = win ? R1_WDAT : R0_WDAT;
                    state_d      = ST_BUS;
`ifdef SB_TIMEOUT_EN
                    tmo_cnt_d    = 8'h00;
`endif
                end
            end

            ST_BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (SB_ACK) begin
                    if (!rw_q) begin
                        if (last_grant_q) begin
                            r1_rdat_d = SB_RDAT;
                        end else begin
                            r0_rdat_d = SB_RDAT;
                        end
                    end
                    stb_d     = 1'b0;
                    r0_done_d = ~last_grant_q;
                    r1_done_d = last_grant_q;
                    state_d   = ST_DONE;
                end
`ifdef SB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    stb_d     = 1'b0;
                    r0_done_d = ~last_grant_q;
                    r1_done_d = last_grant_q;
                    r0_err_d  = ~last_grant_q;
                    r1_err_d  = last_grant_q;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'h01;
                end
`endif
            end

            ST_DONE: begin
                // SB_STB is already low here, giving the idle strobe cycle
                // the hard IP needs between transactions.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    assign SB_STB  = stb_q;
    assign SB_RW   = rw_q;
    assign SB_ADR  = adr_q;
    assign SB_WDAT = wdat_q;
    assign R0_DONE = r0_done_q;
    assign R1_DONE = r1_done_q;
    assign R0_RDAT = r0_rdat_q;
    assign R1_RDAT = r1_rdat_q;

`ifdef SB_TIMEOUT_EN
    assign R0_ERR  = r0_err_q;
    assign R1_ERR  = r1_err_q;
`else
    assign R0_ERR  = 1'b0;
    assign R1_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// Self-checking bench for sb_bus_arbiter. Expected completions are queued
// when a request is issued and popped when a DONE pulse appears.
module tb_sb_bus_arbiter;

    logic       SBCLKI = 1'b0;
    logic       RST;
    logic       R0_REQ, R0_WE, R1_REQ, R1_WE;
    logic [7:0] R0_ADR, R0_WDAT, R1_ADR, R1_WDAT;
    logic       R0_DONE, R1_DONE, R0_ERR, R1_ERR;
    logic [7:0] R0_RDAT, R1_RDAT;
    logic       SB_STB, SB_RW, SB_ACK;
    logic [7:0] SB_ADR, SB_WDAT, SB_RDAT;

    sb_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .SBCLKI (SBCLKI),
        .RST    (RST),
        .R0_REQ (R0_REQ),
        .R0_WE  (R0_WE),
        .R0_ADR (R0_ADR),
        .R0_WDAT(R0_WDAT),
        .R0_DONE(R0_DONE),
        .R0_RDAT(R0_RDAT),
        .R0_ERR (R0_ERR),
        .R1_REQ (R1_REQ),
        .R1_WE  (R1_WE),
        .R1_ADR (R1_ADR),
        .R1_WDAT(R1_WDAT),
        .R1_DONE(R1_DONE),
        .R1_RDAT(R1_RDAT),
        .R1_ERR (R1_ERR),
        .SB_STB (SB_STB),
        .SB_RW  (SB_RW),
        .SB_ADR (SB_ADR),
        .SB_WDAT(SB_WDAT),
        .SB_RDAT(SB_RDAT),
        .SB_ACK (SB_ACK)
    );

    always #5 SBCLKI = ~SBCLKI;

    typedef struct packed {
        logic       owner;
        logic       err;
        logic [7:0] rdat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_r0 = 8'h00;
    logic [7:0] m_r1 = 8'h00;

    wire [37:0] all_outs = {SB_STB, SB_RW, SB_ADR, SB_WDAT, R0_DONE, R1_DONE,
                            R0_ERR, R1_ERR, R0_RDAT, R1_RDAT};

    task automatic step();
        @(negedge SBCLKI);
    endtask

    task automatic idle_inputs();
        R0_REQ = 1'b0; R0_WE = 1'b0; R0_ADR = 8'h00; R0_WDAT = 8'h00;
        R1_REQ = 1'b0; R1_WE = 1'b0; R1_ADR = 8'h00; R1_WDAT = 8'h00;
        SB_ACK = 1'b0; SB_RDAT = 8'h00;
    endtask

    // Scoreboard: every DONE pulse must match the oldest queued expectation.
    always @(negedge SBCLKI) begin
        if (RST === 1'b0 && (R0_DONE === 1'b1 || R1_DONE === 1'b1)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: got done={%b,%b} required no done", R0_DONE, R1_DONE);
            end else begin
                e = exp_q.pop_front();
                if ({R0_DONE, R1_DONE} !== (e.owner ? 2'b01 : 2'b10) ||
                    (e.owner ? R1_ERR : R0_ERR) !== e.err ||
                    (e.owner ? R1_RDAT : R0_RDAT) !== e.rdat ||
                    SB_STB !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sb_done: got done={%b,%b} err={%b,%b} rdat={%h,%h} stb=%b required owner=%0d err=%b rdat=%h stb=0",
                             R0_DONE, R1_DONE, R0_ERR, R1_ERR, R0_RDAT, R1_RDAT, SB_STB, e.owner, e.err, e.rdat);
                end
            end
        end
    end

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        step(); step();
        n_checks++;
        if (all_outs !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", all_outs);
        end
        m_r0 = 8'h00; m_r1 = 8'h00;
        RST = 1'b0;
        step(); step();
        n_checks++;
        if (all_outs !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required 0", all_outs);
        end
    endtask

    task automatic test_write();
        R0_REQ = 1'b1; R0_WE = 1'b1; R0_ADR = 8'h18; R0_WDAT = 8'hA5;
        exp_q.push_back('{owner: 1'b0, err: 1'b0, rdat: m_r0});
        for (int c = 1; c <= 2; c++) begin
            step();
            n_checks++;
            if ({SB_STB, SB_RW, SB_ADR, SB_WDAT} !== {1'b1, 1'b1, 8'h18, 8'hA5}) begin
                n_fail++;
                $display("FAIL write_strobe_c%0d: got stb=%b rw=%b adr=%h wdat=%h required 1 1 18 a5",
                         c, SB_STB, SB_RW, SB_ADR, SB_WDAT);
            end
        end
        SB_ACK = 1'b1;
        step();
        n_checks++;
        if ({R0_DONE, SB_STB, R0_RDAT} !== {1'b1, 1'b0, m_r0}) begin
            n_fail++;
            $display("FAIL write_done_c3: got done=%b stb=%b rdat=%h required 1 0 %h", R0_DONE, SB_STB, R0_RDAT, m_r0);
        end
        SB_ACK = 1'b0; R0_REQ = 1'b0;
        step();
        n_checks++;
        if ({R0_DONE, SB_STB} !== 2'b00) begin
            n_fail++;
            $display("FAIL write_idle_c4: got done=%b stb=%b required 0 0", R0_DONE, SB_STB);
        end
    endtask

    task automatic test_read();
        R1_REQ = 1'b1; R1_WE = 1'b0; R1_ADR = 8'h1C; R1_WDAT = 8'hEE;
        m_r1 = 8'h3C;
        exp_q.push_back('{owner: 1'b1, err: 1'b0, rdat: m_r1});
        step();
        n_checks++;
        if ({SB_STB, SB_RW, SB_ADR} !== {1'b1, 1'b0, 8'h1C}) begin
            n_fail++;
            $display("FAIL read_strobe: got stb=%b rw=%b adr=%h required 1 0 1c", SB_STB, SB_RW, SB_ADR);
        end
        SB_ACK = 1'b1; SB_RDAT = 8'h3C;
        step();
        n_checks++;
        if ({R1_DONE, SB_STB, R1_RDAT, R0_RDAT} !== {1'b1, 1'b0, 8'h3C, m_r0}) begin
            n_fail++;
            $display("FAIL read_done: got done=%b stb=%b r1_rdat=%h r0_rdat=%h required 1 0 3c %h",
                     R1_DONE, SB_STB, R1_RDAT, R0_RDAT, m_r0);
        end
        SB_ACK = 1'b0; R1_REQ = 1'b0; SB_RDAT = 8'h77;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({R1_DONE, R1_RDAT} !== {1'b0, 8'h3C}) begin
                n_fail++;
                $display("FAIL read_hold_%0d: got done=%b rdat=%h required 0 3c", c, R1_DONE, R1_RDAT);
            end
        end
    endtask

    // Both requesters contend; an immediate-ack responder serves the bus.
    task automatic contend(input logic [7:0] rdat_resp, input logic [7:0] g0, input logic [7:0] g1,
                           input string tag);
        logic [7:0] grants[$];
        logic       prev_stb;
        int         d0, d1, overlap;
        prev_stb = 1'b0; d0 = 0; d1 = 0; overlap = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (SB_STB === 1'b1 && !prev_stb) grants.push_back(SB_ADR);
            if (SB_STB === 1'b1 && (R0_DONE === 1'b1 || R1_DONE === 1'b1)) overlap++;
            if (R0_DONE === 1'b1) begin d0++; R0_REQ = 1'b0; end
            if (R1_DONE === 1'b1) begin d1++; R1_REQ = 1'b0; end
            prev_stb = SB_STB;
            SB_ACK   = SB_STB;
            SB_RDAT  = rdat_resp;
        end
        SB_ACK = 1'b0;
        n_checks++;
        if (grants.size() != 2) begin
            n_fail++;
            $display("FAIL %s_grant_count: got %0d required 2", tag, grants.size());
        end else begin
            n_checks++;
            if (grants[0] !== g0 || grants[1] !== g1) begin
                n_fail++;
                $display("FAIL %s_grant_order: got %h,%h required %h,%h", tag, grants[0], grants[1], g0, g1);
            end
        end
        n_checks++;
        if (d0 != 1 || d1 != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got r0=%0d r1=%0d required 1 1", tag, d0, d1);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL %s_stb_over_done: got %0d required 0", tag, overlap);
        end
    endtask

    task automatic test_contention();
        RST = 1'b1;
        idle_inputs();
        R0_REQ = 1'b1; R0_WE = 1'b1; R0_ADR = 8'h20; R0_WDAT = 8'h11;
        R1_REQ = 1'b1; R1_WE = 1'b0; R1_ADR = 8'h21; R1_WDAT = 8'h00;
        step();
        m_r0 = 8'h00; m_r1 = 8'h5A;
        exp_q.push_back('{owner: 1'b0, err: 1'b0, rdat: 8'h00});
        exp_q.push_back('{owner: 1'b1, err: 1'b0, rdat: 8'h5A});
        RST = 1'b0;
        contend(8'h5A, 8'h20, 8'h21, "contention");
    endtask

    task automatic test_stray_ack();
        int stb_cnt;
        logic [7:0] vals[2];
        SB_ACK = 1'b1;
        stb_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (SB_STB === 1'b1) stb_cnt++;
        end
        n_checks++;
        if (stb_cnt != 0) begin
            n_fail++;
            $display("FAIL stray_ack_idle: got %0d strobe cycles required 0", stb_cnt);
        end
        vals[0] = 8'hC3; vals[1] = 8'h00;
        for (int t = 0; t < 2; t++) begin
            m_r0 = vals[t];
            exp_q.push_back('{owner: 1'b0, err: 1'b0, rdat: m_r0});
            R0_REQ = 1'b1; R0_WE = 1'b0; R0_ADR = 8'h60; SB_RDAT = vals[t];
            stb_cnt = 0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (SB_STB === 1'b1) stb_cnt++;
                if (R0_DONE === 1'b1) R0_REQ = 1'b0;
            end
            n_checks++;
            if (stb_cnt != 1 || R0_RDAT !== vals[t]) begin
                n_fail++;
                $display("FAIL held_ack_read_%0d: got %0d strobes rdat=%h required 1 %h", t, stb_cnt, R0_RDAT, vals[t]);
            end
        end
        SB_ACK = 1'b0;
    endtask

    task automatic test_reset_mid();
        R1_REQ = 1'b1; R1_WE = 1'b1; R1_ADR = 8'h30; R1_WDAT = 8'h44;
        step();
        n_checks++;
        if ({SB_STB, SB_ADR} !== {1'b1, 8'h30}) begin
            n_fail++;
            $display("FAIL reset_mid_bus: got stb=%b adr=%h required 1 30", SB_STB, SB_ADR);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if (all_outs !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h required 0", all_outs);
        end
        R0_REQ = 1'b1; R0_WE = 1'b0; R0_ADR = 8'h31;
        m_r0 = 8'h00; m_r1 = 8'h00;
        step();
        n_checks++;
        if (all_outs !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_mid_held: got %h required 0", all_outs);
        end
        m_r0 = 8'h9C;
        exp_q.push_back('{owner: 1'b0, err: 1'b0, rdat: 8'h9C});
        exp_q.push_back('{owner: 1'b1, err: 1'b0, rdat: 8'h00});
        RST = 1'b0;
        contend(8'h9C, 8'h31, 8'h30, "after_reset");
    endtask

    task automatic test_late_drop();
        int extra;
        R1_REQ = 1'b1; R1_WE = 1'b1; R1_ADR = 8'h40; R1_WDAT = 8'h66;
        exp_q.push_back('{owner: 1'b1, err: 1'b0, rdat: m_r1});
        step();
        R1_REQ = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if ({SB_STB, SB_ADR, SB_WDAT} !== {1'b1, 8'h40, 8'h66}) begin
                n_fail++;
                $display("FAIL late_drop_bus_c%0d: got stb=%b adr=%h wdat=%h required 1 40 66", c, SB_STB, SB_ADR, SB_WDAT);
            end
            if (c < 3) step();
        end
        SB_ACK = 1'b1;
        step();
        n_checks++;
        if ({R1_DONE, SB_STB} !== 2'b10) begin
            n_fail++;
            $display("FAIL late_drop_done: got done=%b stb=%b required 1 0", R1_DONE, SB_STB);
        end
        SB_ACK = 1'b0;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (SB_STB !== 1'b0 || R1_DONE !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL late_drop_quiet: got %0d active cycles required 0", extra);
        end
    endtask

`ifdef SB_TIMEOUT_EN
    task automatic test_timeout();
        int   stb_cnt, err_early;
        logic seen;
        for (int t = 0; t < 2; t++) begin
            if (t == 1) m_r0 = 8'hD7;
            exp_q.push_back('{owner: 1'b0, err: (t == 0), rdat: m_r0});
            R0_REQ = 1'b1; R0_WE = 1'b0; R0_ADR = 8'h50; SB_RDAT = 8'hD7;
            stb_cnt = 0; err_early = 0; seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                SB_ACK = 1'b0;
                if (SB_STB === 1'b1) begin
                    stb_cnt++;
                    if (R0_ERR !== 1'b0) err_early++;
                    if (t == 1 && stb_cnt == 4) SB_ACK = 1'b1;
                end
                if (R0_DONE === 1'b1) begin
                    seen = 1'b1;
                    R0_REQ = 1'b0;
                end
            end
            SB_ACK = 1'b0;
            n_checks++;
            if (!seen || stb_cnt != 4 || err_early != 0) begin
                n_fail++;
                $display("FAIL timeout_%0d: got done_seen=%b strobes=%0d early_err=%0d required 1 4 0",
                         t, seen, stb_cnt, err_early);
            end
            step();
            n_checks++;
            if ({R0_ERR, R0_DONE} !== 2'b00) begin
                n_fail++;
                $display("FAIL timeout_err_clear_%0d: got err=%b done=%b required 0 0", t, R0_ERR, R0_DONE);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_stray_ack();
        test_reset_mid();
        test_late_drop();
`ifdef SB_TIMEOUT_EN
        test_timeout();
`endif
        step(); step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: got %0d outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
